multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 35 +++
 rtl/multicycle_controller_bus_wait_timer.sv | 30 +++
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// immediate/ALU select codes and the default bus timeout.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;

  // True for the four opcodes this controller knows how to sequence.
  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_controller_bus_wait_timer.sv
// Counts consecutive cycles a bus request goes unanswered and flags the
// cycle whose increment would reach TIMEOUT_CYCLES.
module bus_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  logic [7:0] count_q;

  // expired is combinational so the FSM can leave on the same edge that
  // would have made the count equal to TIMEOUT_CYCLES.
  assign expired = count_en && (count_q == 8'(TIMEOUT_CYCLES - 1));

  // Wait counter: clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (count_en) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch / decode / execute / memory / writeback
// sequencing for R, LOAD, STORE and BEQ, with a bus-wait timeout that
// drops into a sticky FAULT state.
//
// Bus handshake: bus_req is held high for every cycle the controller wants
// the bus (FETCH and MEM). The transfer completes in the cycle where
// bus_req=1 and bus_ready=1; bus_ready is ignored while bus_req=0.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        bus_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_sel_data,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  ImmSel,
  output logic [1:0]  aluOP,
  output logic        aluSrc,
  output logic        reg_write_en,
  output logic        MemtoReg,
  output logic [2:0]  state,
  output logic        fault,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic [6:0]  op_q;
  logic        in_bus_state;
  logic        wait_count_en;
  logic        wait_clear;
  logic        wait_expired;
  logic [1:0]  dec_imm_sel;
  logic [1:0]  dec_alu_op;
  logic        dec_alu_src;

  assign state = state_q;

  // Bus states derived from the state register only, so the timer does not
  // depend on the next-state logic it feeds.
  assign in_bus_state  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_count_en = in_bus_state && !bus_ready;
  // FETCH/MEM are only ever left by an acknowledge or a timeout.
  assign wait_clear    = bus_ready || wait_expired || !in_bus_state;

  bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (wait_count_en),
    .clear    (wait_clear),
    .expired  (wait_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode latch, captured during DECODE and used through WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= 7'd0;
    end else if (state_q == ST_DECODE) begin
      op_q <= opcode;
    end
  end

  // Retired-instruction counter: one per return to FETCH from a later stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= 32'd0;
    end else if ((state_d == ST_FETCH) &&
                 ((state_q == ST_EXECUTE) || (state_q == ST_MEM) || (state_q == ST_WB))) begin
      instret <= instret + 32'd1;
    end
  end

  // ALU/immediate controls implied by the latched opcode.
  always_comb begin
    dec_imm_sel = IMM_I;
    dec_alu_op  = ALU_ADD;
    dec_alu_src = 1'b0;
    case (op_q)
      OP_R:     begin dec_alu_op = ALU_FUNCT; dec_alu_src = 1'b0; dec_imm_sel = IMM_I; end
      OP_LOAD:  begin dec_alu_op = ALU_ADD;   dec_alu_src = 1'b1; dec_imm_sel = IMM_I; end
      OP_STORE: begin dec_alu_op = ALU_ADD;   dec_alu_src = 1'b1; dec_imm_sel = IMM_S; end
      OP_BEQ:   begin dec_alu_op = ALU_SUB;   dec_alu_src = 1'b0; dec_imm_sel = IMM_B; end
      default:  begin dec_alu_op = ALU_ADD;   dec_alu_src = 1'b0; dec_imm_sel = IMM_I; end
    endcase
  end

  // Next-state and per-state outputs; everything not driven by a state is 0.
  always_comb begin
    state_d      = state_q;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_sel_data = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ImmSel       = IMM_I;
    aluOP        = ALU_ADD;
    aluSrc       = 1'b0;
    reg_write_en = 1'b0;
    MemtoReg     = 1'b0;
    fault        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        bus_req = 1'b1;
        if (bus_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        state_d = is_legal(opcode) ? ST_EXECUTE : ST_FAULT;
      end
      ST_EXECUTE: begin
        ImmSel = dec_imm_sel;
        aluOP  = dec_alu_op;
        aluSrc = dec_alu_src;
        case (op_q)
          OP_R:              state_d = ST_WB;
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_BEQ: begin
            state_d  = ST_FETCH;
            pc_write = zero;
            pc_src   = zero;
          end
          default:           state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        bus_req      = 1'b1;
        bus_sel_data = 1'b1;
        bus_we       = (op_q == OP_STORE);
        ImmSel       = dec_imm_sel;
        aluOP        = dec_alu_op;
        aluSrc       = dec_alu_src;
        if (bus_ready) begin
          state_d = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_write_en = 1'b1;
        MemtoReg     = (op_q == OP_LOAD);
        state_d      = ST_FETCH;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios followed by random
// instruction streams, checked cycle by cycle against an instruction-level
// model of what each stage must drive.
module tb_multicycle_controller;

  localparam int TMO = 4;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BQ_OP = 7'b1100011;

  typedef struct packed {
    logic       bus_req;
    logic       bus_we;
    logic       sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] imm_sel;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write_en;
    logic       mem_to_reg;
    logic       fault;
  } ctl_t;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        bus_ready;
  logic        bus_req, bus_we, bus_sel_data, ir_write, pc_write, pc_src;
  logic [1:0]  ImmSel, aluOP;
  logic        aluSrc, reg_write_en, MemtoReg, fault;
  logic [2:0]  state;
  logic [31:0] instret;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instret = 32'd0;

  multicycle_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .zero         (zero),
    .bus_ready    (bus_ready),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_sel_data (bus_sel_data),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ImmSel       (ImmSel),
    .aluOP        (aluOP),
    .aluSrc       (aluSrc),
    .reg_write_en (reg_write_en),
    .MemtoReg     (MemtoReg),
    .state        (state),
    .fault        (fault),
    .instret      (instret)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the ALU/immediate controls each opcode calls for.
  function automatic ctl_t alu_ctl(input logic [6:0] op);
    ctl_t e;
    e = '0;
    case (op)
      R_OP:  begin e.alu_op = 2'b10; e.alu_src = 1'b0; e.imm_sel = 2'b00; end
      LD_OP: begin e.alu_op = 2'b00; e.alu_src = 1'b1; e.imm_sel = 2'b00; end
      ST_OP: begin e.alu_op = 2'b00; e.alu_src = 1'b1; e.imm_sel = 2'b01; end
      BQ_OP: begin e.alu_op = 2'b01; e.alu_src = 1'b0; e.imm_sel = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return (op == R_OP) || (op == LD_OP) || (op == ST_OP) || (op == BQ_OP);
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  // Compare all outputs against expectations for the current cycle.
  task automatic check_all(input logic [2:0] es, input ctl_t e, input string tag);
    ctl_t obs;
    obs = '{bus_req, bus_we, bus_sel_data, ir_write, pc_write, pc_src,
            ImmSel, aluOP, aluSrc, reg_write_en, MemtoReg, fault};
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s ctl: observed %h expected %h", tag, obs, e);
    end
    n_checks++;
    assert (state === es) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
    end
    n_checks++;
    assert (instret === exp_instret) else begin
      n_fail++;
      $error("FAIL %s instret: observed %0d expected %0d", tag, instret, exp_instret);
    end
  endtask

  // One clock cycle: drive on the falling edge, check 1ns later.
  task automatic cyc(input logic [6:0] op, input logic z, input logic rdy,
                     input logic [2:0] es, input ctl_t e, input string tag);
    @(negedge clk);
    reset     = 1'b0;
    opcode    = op;
    zero      = z;
    bus_ready = rdy;
    #1;
    check_all(es, e, tag);
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic async_reset(input string tag);
    ctl_t e;
    e = '0;
    reset = 1'b1;
    exp_instret = 32'd0;
    #1;
    check_all(3'd0, e, tag);
  endtask

  // Release reset: one IDLE cycle precedes the first fetch.
  task automatic release_reset();
    ctl_t e;
    e = '0;
    cyc(rop(), rbit(), rbit(), 3'd0, e, "idle");
  endtask

  task automatic fault_hold(input int n);
    ctl_t e;
    e = '0;
    e.fault = 1'b1;
    for (int i = 0; i < n; i++) cyc(rop(), rbit(), rbit(), 3'd6, e, "fault_hold");
  endtask

  // One instruction from FETCH. outcome: 0 retired, 1 fault, 2 reset in MEM.
  task automatic run_instr(input logic [6:0] op, input logic z, input int fw,
                           input int mw, input bit rst_mid, output int outcome);
    ctl_t e;
    outcome = 0;
    for (int i = 0; i <= fw; i++) begin
      e = '0;
      e.bus_req = 1'b1;
      if (i == fw) begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        cyc(rop(), rbit(), 1'b1, 3'd1, e, "fetch_ack");
      end else begin
        cyc(rop(), rbit(), 1'b0, 3'd1, e, "fetch_wait");
        if (i == TMO - 1) begin
          outcome = 1;
          return;
        end
      end
    end
    e = '0;
    cyc(op, rbit(), rbit(), 3'd2, e, "decode");
    if (!legal(op)) begin
      outcome = 1;
      return;
    end
    e = alu_ctl(op);
    if (op == BQ_OP && z) begin
      e.pc_write = 1'b1;
      e.pc_src   = 1'b1;
    end
    cyc(rop(), z, rbit(), 3'd3, e, "execute");
    if (op == BQ_OP) begin
      exp_instret++;
      return;
    end
    if (op == R_OP) begin
      e = '0;
      e.reg_write_en = 1'b1;
      cyc(rop(), rbit(), rbit(), 3'd5, e, "wb_r");
      exp_instret++;
      return;
    end
    for (int i = 0; i <= mw; i++) begin
      e = alu_ctl(op);
      e.bus_req = 1'b1;
      e.sel     = 1'b1;
      e.bus_we  = (op == ST_OP);
      if (i == mw) begin
        cyc(rop(), rbit(), 1'b1, 3'd4, e, "mem_ack");
      end else begin
        cyc(rop(), rbit(), 1'b0, 3'd4, e, "mem_wait");
        if (rst_mid && i == 1) begin
          async_reset("reset_mid_mem");
          outcome = 2;
          return;
        end
        if (i == TMO - 1) begin
          outcome = 1;
          return;
        end
      end
    end
    if (op == LD_OP) begin
      e = '0;
      e.reg_write_en = 1'b1;
      e.mem_to_reg   = 1'b1;
      cyc(rop(), rbit(), rbit(), 3'd5, e, "wb_load");
    end
    exp_instret++;
  endtask

  // After a fault: confirm it sticks, then reset and restart.
  task automatic recover();
    fault_hold(3);
    @(negedge clk);
    async_reset("reset_from_fault");
    release_reset();
  endtask

  // Directed scenarios, then randomized instruction stream.
  initial begin
    int outcome;
    ctl_t e;
    reset     = 1'b1;
    opcode    = 7'd0;
    zero      = 1'b0;
    bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = '0;
    check_all(3'd0, e, "reset_state");
    release_reset();

    run_instr(R_OP, 1'b0, 0, 0, 1'b0, outcome);
    run_instr(LD_OP, 1'b0, 0, 3, 1'b0, outcome);
    run_instr(BQ_OP, 1'b1, 0, 0, 1'b0, outcome);
    run_instr(BQ_OP, 1'b0, 0, 0, 1'b0, outcome);
    run_instr(ST_OP, 1'b0, 1, 0, 1'b0, outcome);

    // Acknowledge on the last permitted cycle wins over the timeout.
    run_instr(R_OP, 1'b0, TMO - 1, 0, 1'b0, outcome);
    run_instr(LD_OP, 1'b0, 0, TMO - 1, 1'b0, outcome);
    // No acknowledge: timeout into FAULT.
    run_instr(R_OP, 1'b0, TMO, 0, 1'b0, outcome);
    n_checks++;
    assert (outcome == 1) else begin
      n_fail++;
      $error("FAIL fetch_timeout_outcome: observed %0d expected 1", outcome);
    end
    recover();

    run_instr(7'b0010011, 1'b0, 0, 0, 1'b0, outcome);
    recover();

    run_instr(ST_OP, 1'b0, 0, TMO + 1, 1'b0, outcome);
    recover();

    run_instr(R_OP, 1'b0, 0, 0, 1'b0, outcome);
    run_instr(ST_OP, 1'b0, 0, 3, 1'b1, outcome);
    release_reset();

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      int sel, fw, mw;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 9: op = R_OP;
        2, 3:    op = LD_OP;
        4, 5:    op = ST_OP;
        6, 7:    op = BQ_OP;
        default: begin
          op = rop();
          if (legal(op)) op = op ^ 7'b0000100;
        end
      endcase
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, TMO - 1);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, TMO - 1);
      run_instr(op, rbit(), fw, mw, 1'b0, outcome);
      if (outcome == 1) recover();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
